pic_irq_core: RTL and testbench
===============================

PIC_IRQ_CORE -- requirements
Module: pic_irq_core

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 8: number of request channels, a power of two from 2 to 32.
REQ-002 The block SHALL have parameter VEC_W, default 8: vector width; ID_W = clog2(NUM_IRQ) is derived.
REQ-003 The block SHALL have port clock, input, 1: the single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port write_enable, input, 1: one-cycle register write strobe.
REQ-006 The block SHALL have port read_enable, input, 1: one-cycle register read strobe.
REQ-007 The block SHALL have port address, input, 2: register select.
REQ-008 The block SHALL have port write_data, input, 32: write payload.
REQ-009 The block SHALL have port read_data, output, 32: read payload, zero-extended.
REQ-010 The block SHALL have port irq_in, input, NUM_IRQ: requests, synchronous to clock.
REQ-011 The block SHALL have port inta_n, input, 1: active-low acknowledge, sampled on clock.
REQ-012 The block SHALL have port int_out, output, 1: registered interrupt request to the CPU.
REQ-013 The block SHALL have port vector_out, output, VEC_W: acknowledged vector.
REQ-014 The block SHALL have port vector_valid, output, 1: one-cycle qualifier for vector_out.

Function
REQ-015 Writes SHALL decode as: address 0 = CTRL (bit0 aeoi, bit1 rotate_on_aeoi); 1 = IMR; 2 = TRIG (1 = level, 0 = rising edge, per channel); 3 = EOI command (bit8 specific, bit9 rotate, [ID_W-1:0] id).
REQ-016 Reads SHALL decode as: address 0 = IRR; 1 = IMR; 2 = ISR; 3 = {lowest_prio, vector_base[VEC_W-1:0]} in bits [ID_W+15:16] and [VEC_W-1:0].
REQ-017 read_data SHALL update in the cycle after the read_enable cycle and hold until the next read.
REQ-018 vector_base SHALL be written via address 3 when write_data bit10 = 1; bit10 = 1 SHALL suppress the EOI action.
REQ-019 An edge channel SHALL set IRR[i] on a 0->1 transition of irq_in[i] against its registered previous sample.
REQ-020 A level channel SHALL have IRR[i] follow irq_in[i] each cycle.
REQ-021 Priority SHALL be rotating: channel (lowest_prio+1) mod NUM_IRQ is highest, descending cyclically to lowest_prio.
REQ-022 The winner SHALL be the highest-priority bit of IRR & ~IMR.
REQ-023 int_out SHALL rise one cycle after a winner exists whose priority is strictly above every set ISR bit (fully nested).
REQ-024 The ack FSM SHALL have states IDLE, ACK1 and ACK2; a falling edge of inta_n is a 1->0 change of the registered sample.
REQ-025 In IDLE, a falling edge SHALL latch the winner id, set ISR[id], clear IRR[id] for edge channels, drop int_out, and go to ACK1.
REQ-026 With no winner at the first edge, the latched id SHALL be NUM_IRQ-1, no ISR bit SHALL be set, and the cycle is spurious.
REQ-027 In ACK1, the next falling edge SHALL go to ACK2.
REQ-028 ACK2 SHALL last one cycle: vector_valid = 1 and vector_out = (vector_base + id) mod 2^VEC_W; the FSM then returns to IDLE.
REQ-029 On leaving ACK2 with aeoi = 1, ISR[id] SHALL clear; with rotate_on_aeoi = 1 as well, lowest_prio SHALL become id.
REQ-030 int_out SHALL stay low from ACK1 entry through ACK2 and re-evaluate in IDLE.
REQ-031 A non-specific EOI SHALL clear the highest-priority set ISR bit and SHALL have no effect when ISR = 0.
REQ-032 A specific EOI SHALL clear ISR[id].
REQ-033 With rotate = 1, an EOI SHALL set lowest_prio to the cleared id; when nothing is cleared, lowest_prio is unchanged.
REQ-034 A new edge on irq_in[i] in the same cycle an ack clears IRR[i] SHALL leave IRR[i] = 1.
REQ-035 An ack setting ISR[i] in the same cycle an EOI clears ISR[i] SHALL leave ISR[i] = 1.
REQ-036 Masking SHALL affect only arbitration; IRR SHALL still capture masked requests.

Reset
REQ-037 On reset = 1 the block SHALL immediately clear IRR, ISR, IMR, TRIG, CTRL and vector_base, set lowest_prio = NUM_IRQ-1, return the FSM to IDLE, and drive int_out, vector_valid, vector_out and read_data to 0.
REQ-038 Reset mid-ack SHALL abandon the sequence with no vector_valid pulse.
REQ-039 The previous-sample registers SHALL reset to 0, so an irq_in held high through reset release SHALL register as an edge.

Verification
REQ-040 Scenario: base = 0xA8, IMR = 0, edge pulse on irq_in[0], two inta_n pulses -> vector 0xA8, ISR = 0x01; specific EOI id 0 -> ISR = 0x00.
REQ-041 Scenario: ISR[4] set, pulses on channels 5 then 3 -> no int_out for 5; int_out for 3, vector base+3; after EOI 3 and EOI 4, channel 5 is delivered.
REQ-042 Scenario: IMR = 0xFF, irq_in = 0xFF -> IRR = 0xFF, int_out = 0; IMR = 0xFE -> int_out rises the next cycle, vector base+0.
REQ-043 Scenario: aeoi = 1, rotate_on_aeoi = 1, irq_in = 0xFF pulsed, 8 ack pairs -> vectors base+0..base+7 in order, ISR stays 0, lowest_prio ends at 7.
REQ-044 Scenario: ack with IRR = 0 -> vector base+NUM_IRQ-1, ISR unchanged; reset asserted in ACK1 -> no vector_valid, all registers at reset values.
REQ-045 Scenario: NUM_IRQ = 16, VEC_W = 4, base = 0xF, irq 3 acknowledged -> vector_out = 0x2 (wrap).

Source files
------------

// File: rtl/pic_irq_core.sv
// Programmable interrupt controller core: edge/level request capture, rotating
// priority arbitration with full nesting, two-pulse acknowledge and EOI handling.
module pic_irq_core #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               write_enable,
    input  logic               read_enable,
    input  logic [1:0]         address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               inta_n,
    output logic               int_out,
    output logic [VEC_W-1:0]   vector_out,
    output logic               vector_valid
);

    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {IDLE, ACK1, ACK2} state_t;

    // Distance below the current top-priority channel; smaller means more urgent.
    function automatic logic [ID_W-1:0] rank_of(input logic [ID_W-1:0] ch,
                                                input logic [ID_W-1:0] lp);
        return ch - lp - ID_W'(1);
    endfunction

    function automatic logic [ID_W:0] pick_highest(input logic [NUM_IRQ-1:0] vec,
                                                   input logic [ID_W-1:0]    lp);
        logic            found;
        logic [ID_W-1:0] ch;
        logic [ID_W-1:0] id;
        found = 1'b0;
        id    = '0;
        for (int k = 0; k < NUM_IRQ; k++) begin
            ch = lp + ID_W'(1) + ID_W'(k);
            if (!found && vec[ch]) begin
                found = 1'b1;
                id    = ch;
            end
        end
        return {found, id};
    endfunction

    state_t             state, state_next;
    logic [NUM_IRQ-1:0] irr, isr, imr, trig, irq_prev;
    logic [NUM_IRQ-1:0] irr_next, isr_next, ack_set, eoi_clr, aeoi_clr;
    logic               aeoi, rot_aeoi;
    logic [VEC_W-1:0]   vector_base;
    logic [ID_W-1:0]    lowest_prio, lowest_prio_next;
    logic [ID_W-1:0]    ack_id;
    logic               ack_spur;
    logic               inta_prev;
    logic               int_next;
    logic [31:0]        read_mux;

    logic               inta_fall, ack_take, pending;
    logic               win_valid, isr_valid;
    logic [ID_W-1:0]    win_id, isr_top;
    logic               eoi_cmd, eoi_hit, aeoi_hit;
    logic [ID_W-1:0]    eoi_id;
    logic               unused_bits;

    assign unused_bits = ^write_data;

    assign inta_fall              = inta_prev & ~inta_n;
    assign {win_valid, win_id}    = pick_highest(irr & ~imr, lowest_prio);
    assign {isr_valid, isr_top}   = pick_highest(isr, lowest_prio);
    assign pending  = win_valid &&
                      (!isr_valid || (rank_of(win_id, lowest_prio) < rank_of(isr_top, lowest_prio)));
    assign ack_take = (state == IDLE) && inta_fall;

    // A base write (bit10) shares the address with EOI and suppresses it.
    assign eoi_cmd  = write_enable && (address == 2'd3) && !write_data[10];
    assign eoi_id   = write_data[8] ? write_data[ID_W-1:0] : isr_top;
    assign eoi_hit  = eoi_cmd && (write_data[8] ? isr[write_data[ID_W-1:0]] : isr_valid);
    assign aeoi_hit = (state == ACK2) && aeoi && !ack_spur;

    assign ack_set  = NUM_IRQ'(ack_take && win_valid) << win_id;
    assign eoi_clr  = NUM_IRQ'(eoi_hit) << eoi_id;
    assign aeoi_clr = NUM_IRQ'(aeoi_hit) << ack_id;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        lowest_prio_next = lowest_prio;
        // Clear-then-set ordering lets a fresh edge or ack win over a same-cycle clear.
        irr_next = (trig & irq_in) | (~trig & ((irr & ~ack_set) | (irq_in & ~irq_prev)));
        isr_next = (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        if (eoi_hit && write_data[9])
            lowest_prio_next = eoi_id;
        else if (aeoi_hit && rot_aeoi)
            lowest_prio_next = ack_id;
    end

    always_comb begin
        read_mux = '0;
        case (address)
            2'd0: read_mux[NUM_IRQ-1:0] = irr;
            2'd1: read_mux[NUM_IRQ-1:0] = imr;
            2'd2: read_mux[NUM_IRQ-1:0] = isr;
            default: begin
                read_mux[VEC_W-1:0]  = vector_base;
                read_mux[16 +: ID_W] = lowest_prio;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inta_fall) state_next = ACK1;
            ACK1:    if (inta_fall) state_next = ACK2;
            ACK2:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        vector_valid = (state == ACK2);
        vector_out   = (state == ACK2) ? vector_base + VEC_W'(ack_id) : '0;
        int_next     = (state == IDLE) && !inta_fall && pending;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            irr         <= '0;
            isr         <= '0;
            imr         <= '0;
            trig        <= '0;
            irq_prev    <= '0;
            aeoi        <= 1'b0;
            rot_aeoi    <= 1'b0;
            vector_base <= '0;
            lowest_prio <= ID_W'(NUM_IRQ - 1);
            ack_id      <= '0;
            ack_spur    <= 1'b0;
            inta_prev   <= 1'b0;
            int_out     <= 1'b0;
            read_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            irr         <= irr_next;
            isr         <= isr_next;
            lowest_prio <= lowest_prio_next;
            irq_prev    <= irq_in;
            inta_prev   <= inta_n;
            int_out     <= int_next;
            if (read_enable)
                read_data <= read_mux;
            if (ack_take) begin
                ack_id   <= win_valid ? win_id : ID_W'(NUM_IRQ - 1);
                ack_spur <= !win_valid;
            end
            if (write_enable) begin
                case (address)
                    2'd0: begin
                        aeoi     <= write_data[0];
                        rot_aeoi <= write_data[1];
                    end
                    2'd1: imr  <= write_data[NUM_IRQ-1:0];
                    2'd2: trig <= write_data[NUM_IRQ-1:0];
                    default: if (write_data[10]) vector_base <= write_data[VEC_W-1:0];
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pic_irq_core.sv
// Self-checking bench for pic_irq_core: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pic_irq_core;

    localparam int N = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_enable = 1'b0;
    logic        read_enable = 1'b0;
    logic [1:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [7:0]  irq_in = '0;
    logic        inta_n = 1'b1;
    logic        int_out;
    logic [7:0]  vector_out;
    logic        vector_valid;

    logic [15:0] irq_in2 = '0;
    logic [31:0] read_data2;
    logic        int_out2;
    logic [3:0]  vector_out2;
    logic        vector_valid2;

    int total = 0;
    int bad   = 0;

    pic_irq_core #(.NUM_IRQ(8), .VEC_W(8)) dut (
        .clock(clock), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .write_data(write_data), .read_data(read_data), .irq_in(irq_in),
        .inta_n(inta_n), .int_out(int_out), .vector_out(vector_out), .vector_valid(vector_valid)
    );

    pic_irq_core #(.NUM_IRQ(16), .VEC_W(4)) dut_wide (
        .clock(clock), .reset(reset), .write_enable(write_enable), .read_enable(read_enable),
        .address(address), .write_data(write_data), .read_data(read_data2), .irq_in(irq_in2),
        .inta_n(inta_n), .int_out(int_out2), .vector_out(vector_out2), .vector_valid(vector_valid2)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [7:0]  m_irr, m_isr, m_imr, m_trig, m_prev, m_base;
    bit [1:0]  m_ctrl;
    int        m_lp, m_state, m_id;
    bit        m_spur, m_inta_prev;
    bit        exp_int, exp_vv;
    bit [7:0]  exp_vo;
    bit [31:0] exp_rd;

    function automatic int rank(int ch, int lp);
        return (ch - lp - 1 + 2 * N) % N;
    endfunction

    // Most urgent set channel of v, or -1 when v is empty.
    function automatic int best(bit [7:0] v, int lp);
        int b = -1;
        for (int i = 0; i < N; i++)
            if (v[i] && (b < 0 || rank(i, lp) < rank(b, lp))) b = i;
        return b;
    endfunction

    task automatic model_reset();
        m_irr = 0; m_isr = 0; m_imr = 0; m_trig = 0; m_prev = 0; m_base = 0; m_ctrl = 0;
        m_lp = N - 1; m_state = 0; m_id = 0; m_spur = 0; m_inta_prev = 0;
        exp_int = 0; exp_vv = 0; exp_vo = 0; exp_rd = 0;
    endtask

    task automatic model_step();
        bit       fall, pend, ack;
        int       win, itop, eoi_id, aeoi_id, nlp, nstate;
        bit [7:0] ack_set, nirr, nisr, edges;
        fall = m_inta_prev && !inta_n;
        win  = best(m_irr & ~m_imr, m_lp);
        itop = best(m_isr, m_lp);
        pend = (win >= 0) && (itop < 0 || rank(win, m_lp) < rank(itop, m_lp));
        if (read_enable) begin
            case (address)
                2'd0: exp_rd = {24'h0, m_irr};
                2'd1: exp_rd = {24'h0, m_imr};
                2'd2: exp_rd = {24'h0, m_isr};
                default: exp_rd = (32'(m_lp) << 16) | {24'h0, m_base};
            endcase
        end
        exp_int = (m_state == 0) && !fall && pend;
        ack     = (m_state == 0) && fall;
        ack_set = 0;
        if (ack && win >= 0) ack_set[win] = 1'b1;
        edges = irq_in & ~m_prev;
        for (int i = 0; i < N; i++)
            nirr[i] = m_trig[i] ? irq_in[i] : ((m_irr[i] && !ack_set[i]) || edges[i]);
        eoi_id = -1;
        if (write_enable && address == 2'd3 && !write_data[10]) begin
            if (write_data[8]) begin
                if (m_isr[write_data[2:0]]) eoi_id = int'(write_data[2:0]);
            end else begin
                eoi_id = itop;
            end
        end
        aeoi_id = (m_state == 2 && m_ctrl[0] && !m_spur) ? m_id : -1;
        nisr = m_isr;
        if (eoi_id >= 0)  nisr[eoi_id]  = 1'b0;
        if (aeoi_id >= 0) nisr[aeoi_id] = 1'b0;
        nisr |= ack_set;
        nlp = m_lp;
        if (eoi_id >= 0 && write_data[9])   nlp = eoi_id;
        else if (aeoi_id >= 0 && m_ctrl[1]) nlp = aeoi_id;
        if (write_enable) begin
            case (address)
                2'd0: m_ctrl = write_data[1:0];
                2'd1: m_imr  = write_data[7:0];
                2'd2: m_trig = write_data[7:0];
                default: if (write_data[10]) m_base = write_data[7:0];
            endcase
        end
        nstate = m_state;
        case (m_state)
            0: if (fall) begin
                nstate = 1;
                m_id   = (win >= 0) ? win : N - 1;
                m_spur = (win < 0);
            end
            1: if (fall) nstate = 2;
            default: nstate = 0;
        endcase
        m_irr = nirr; m_isr = nisr; m_lp = nlp; m_state = nstate;
        m_prev = irq_in; m_inta_prev = inta_n;
        exp_vv = (m_state == 2);
        exp_vo = exp_vv ? 8'((int'(m_base) + m_id) % 256) : 8'h00;
    endtask

    always @(posedge clock) begin
        if (reset) model_reset();
        else       model_step();
        #1;
        check("int_out",      32'(int_out),      32'(exp_int));
        check("vector_valid", 32'(vector_valid), 32'(exp_vv));
        check("vector_out",   32'(vector_out),   32'(exp_vo));
        check("read_data",    read_data,         exp_rd);
    end

    // ---------------- stimulus helpers ----------------
    logic       last_vv, last_vv2;
    logic [7:0] last_vo;
    logic [3:0] last_vo2;
    logic [31:0] rv;

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        write_enable = 1'b1; address = a; write_data = d;
        step(1);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        read_enable = 1'b1; address = a;
        step(1);
        read_enable = 1'b0;
        d = read_data;
    endtask

    task automatic pulse_irq(input int ch);
        irq_in = 8'(1 << ch);
        step(1);
        irq_in = '0;
        step(1);
    endtask

    task automatic ack_pair();
        inta_n = 1'b0; step(1);
        inta_n = 1'b1; step(1);
        inta_n = 1'b0; step(1);
        last_vv = vector_valid; last_vo = vector_out;
        last_vv2 = vector_valid2; last_vo2 = vector_out2;
        inta_n = 1'b1; step(1);
    endtask

    task automatic do_reset();
        reset = 1'b1; step(2);
        reset = 1'b0; step(1);
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        #1;
        check("rst int_out", 32'(int_out), 32'h0);
        check("rst vector_valid", 32'(vector_valid), 32'h0);
        check("rst read_data", read_data, 32'h0);
        step(1);
        rd(2'd3, rv); check("rst lowest/base", rv, 32'h0007_0000);
        rd(2'd0, rv); check("rst irr", rv, 32'h0);

        // base 0xA8, edge on channel 0, ack, specific EOI 0
        wr(2'd3, 32'h4A8);
        pulse_irq(0); step(1);
        check("A int_out", 32'(int_out), 32'h1);
        rd(2'd0, rv); check("A irr", rv, 32'h01);
        ack_pair();
        check("A valid", 32'(last_vv), 32'h1);
        check("A vector", 32'(last_vo), 32'hA8);
        rd(2'd2, rv); check("A isr", rv, 32'h01);
        wr(2'd3, 32'h100);
        rd(2'd2, rv); check("A isr after eoi", rv, 32'h00);

        // request held high through reset release counts as an edge
        irq_in = 8'h04;
        do_reset();
        irq_in = '0;
        rd(2'd0, rv); check("held edge irr", rv, 32'h04);

        // masking: IRR captures masked requests, unmask raises int_out next cycle
        do_reset();
        wr(2'd3, 32'h4A8); wr(2'd1, 32'hFF);
        irq_in = 8'hFF; step(2);
        rd(2'd0, rv); check("B irr", rv, 32'hFF);
        check("B masked int", 32'(int_out), 32'h0);
        wr(2'd1, 32'hFE);
        check("B int before", 32'(int_out), 32'h0);
        step(1);
        check("B int after unmask", 32'(int_out), 32'h1);
        ack_pair();
        check("B vector", 32'(last_vo), 32'hA8);
        irq_in = '0;

        // full nesting under an in-service channel 4
        do_reset();
        wr(2'd3, 32'h4A8);
        pulse_irq(4); ack_pair();
        check("C vec4", 32'(last_vo), 32'hAC);
        rd(2'd2, rv); check("C isr", rv, 32'h10);
        pulse_irq(5); step(2);
        check("C no int for 5", 32'(int_out), 32'h0);
        pulse_irq(3); step(1);
        check("C int for 3", 32'(int_out), 32'h1);
        ack_pair();
        check("C vec3", 32'(last_vo), 32'hAB);
        wr(2'd3, 32'h103); wr(2'd3, 32'h104); step(1);
        check("C int for 5", 32'(int_out), 32'h1);
        ack_pair();
        check("C vec5", 32'(last_vo), 32'hAD);

        // auto-EOI with rotation walks every channel in order
        do_reset();
        wr(2'd3, 32'h4A8); wr(2'd0, 32'h3);
        irq_in = 8'hFF; step(1); irq_in = '0; step(1);
        for (int k = 0; k < 8; k++) begin
            ack_pair();
            check($sformatf("D vec%0d", k), 32'(last_vo), 32'(8'hA8 + k));
        end
        rd(2'd2, rv); check("D isr", rv, 32'h0);
        rd(2'd3, rv); check("D lowest", rv, 32'h0007_00A8);

        // spurious ack and reset in the middle of an ack
        do_reset();
        wr(2'd3, 32'h4A8);
        ack_pair();
        check("E spurious valid", 32'(last_vv), 32'h1);
        check("E spurious vec", 32'(last_vo), 32'hAF);
        rd(2'd2, rv); check("E isr", rv, 32'h0);
        inta_n = 1'b0; step(1); inta_n = 1'b1;
        reset = 1'b1; #1;
        check("E rst valid", 32'(vector_valid), 32'h0);
        check("E rst read_data", read_data, 32'h0);
        step(2); reset = 1'b0; step(1);
        inta_n = 1'b0; step(1);
        check("E fresh ack1", 32'(vector_valid), 32'h0);
        inta_n = 1'b1; step(1);
        rd(2'd3, rv); check("E regs reset", rv, 32'h0007_0000);

        // 16 channels, 4-bit vector wraps
        do_reset();
        wr(2'd3, 32'h40F);
        irq_in2 = 16'h0008; step(1); irq_in2 = '0; step(1);
        ack_pair();
        check("F wide valid", 32'(last_vv2), 32'h1);
        check("F wide vector", 32'(last_vo2), 32'h2);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(3) == 0) irq_in = 8'($urandom);
            write_enable = ($urandom_range(7) == 0);
            address      = 2'($urandom);
            write_data   = ($urandom & 32'h3FF) | (($urandom_range(7) == 0) ? 32'h400 : 32'h0);
            read_enable  = ($urandom_range(2) == 0);
            inta_n       = ($urandom_range(3) != 0);
            reset        = ($urandom_range(699) == 0);
            step(1);
        end
        reset = 1'b0; write_enable = 1'b0; read_enable = 1'b0; inta_n = 1'b1;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
